// File: rtl/ase_umsg_scheduler.sv
// Per-slot UMsg hint/data sequencer with a round-robin arbiter feeding one registered output.
// Define ASE_UMSG_STATS_EN to build the hint/data/coalesce statistics counters.
module ase_umsg_scheduler #(
  parameter int NUM_UMSG    = 8,
  parameter int TIMER_WIDTH = 8,
  parameter int HINT_DELAY  = 16,
  parameter int DATA_DELAY  = 16
) (
  input  logic                        clk,
  input  logic                        SoftReset_n,
  input  logic                        umsg_en,
  input  logic                        umsgcmd_valid,
  input  logic [$clog2(NUM_UMSG)-1:0] umsgcmd_id,
  input  logic                        umsgcmd_hint,
  input  logic [511:0]                umsgcmd_data,
  output logic                        umsg_valid,
  input  logic                        umsg_ready,
  output logic [27:0]                 umsg_hdr,
  output logic [511:0]                umsg_data,
  output logic [NUM_UMSG-1:0]         slot_busy,
  output logic [31:0]                 stat_hint_cnt,
  output logic [31:0]                 stat_data_cnt,
  output logic [31:0]                 stat_coalesce_cnt
);
  localparam int ID_W = $clog2(NUM_UMSG);
  localparam logic [TIMER_WIDTH-1:0] HINT_LOAD = TIMER_WIDTH'(HINT_DELAY - 1);
  localparam logic [TIMER_WIDTH-1:0] DATA_LOAD = TIMER_WIDTH'(DATA_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HINT_WAIT, S_SEND_HINT, S_DATA_WAIT, S_SEND_DATA
  } slot_state_e;

  if (HINT_DELAY < 1 || HINT_DELAY > 2**TIMER_WIDTH ||
      DATA_DELAY < 1 || DATA_DELAY > 2**TIMER_WIDTH) begin : g_bad_cfg
    $fatal(1, "ase_umsg_scheduler: HINT_DELAY/DATA_DELAY out of range");
  end

  logic                         cmd_acc;
  logic [NUM_UMSG-1:0]          req;
  logic [NUM_UMSG-1:0]          is_hint;
  logic [NUM_UMSG-1:0][511:0]   slot_data;
  logic                         can_grant;
  logic                         grant_valid;
  logic [ID_W-1:0]              grant_idx;
  logic [ID_W-1:0]              cand;
  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic                         valid_q, valid_d;
  logic [27:0]                  hdr_q, hdr_d;
  logic [511:0]                 odata_q, odata_d;

  assign cmd_acc   = umsgcmd_valid & umsg_en;
  assign can_grant = !valid_q || umsg_ready;

  for (genvar gi = 0; gi < NUM_UMSG; gi++) begin : g_slot
    slot_state_e            state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [511:0]           data_q, data_d;
    logic                   granted;
    logic                   hit;

    assign granted       = grant_valid && (grant_idx == ID_W'(gi));
    assign hit           = cmd_acc && (umsgcmd_id == ID_W'(gi));
    assign req[gi]       = (state_q == S_SEND_HINT) || (state_q == S_SEND_DATA);
    assign is_hint[gi]   = (state_q == S_SEND_HINT);
    assign slot_busy[gi] = (state_q != S_IDLE);
    assign slot_data[gi] = data_q;

    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      data_d  = data_q;
      case (state_q)
        S_HINT_WAIT: if (timer_q == '0) state_d = S_SEND_HINT;
                     else timer_d = timer_q - TIMER_WIDTH'(1);
        S_DATA_WAIT: if (timer_q == '0) state_d = S_SEND_DATA;
                     else timer_d = timer_q - TIMER_WIDTH'(1);
        S_SEND_HINT: if (granted) begin
                       state_d = S_DATA_WAIT;
                       timer_d = DATA_LOAD;
                     end
        S_SEND_DATA: if (granted) state_d = S_IDLE;
        default: ;
      endcase
      // A slot that is (or is just becoming) idle starts a new message; otherwise only the payload is replaced.
      if (hit) begin
        data_d = umsgcmd_data;
        if (state_d == S_IDLE) begin
          state_d = umsgcmd_hint ? S_HINT_WAIT : S_DATA_WAIT;
          timer_d = umsgcmd_hint ? HINT_LOAD : DATA_LOAD;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!SoftReset_n) begin
        state_q <= S_IDLE;
        timer_q <= '0;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        data_q  <= data_d;
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr_q;
    cand        = '0;
    if (can_grant) begin
      for (int k = 1; k <= NUM_UMSG; k++) begin
        cand = ID_W'((int'(ptr_q) + k) % NUM_UMSG);
        if (!grant_valid && req[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    hdr_d   = hdr_q;
    odata_d = odata_q;
    if (grant_valid) begin
      ptr_d        = grant_idx;
      valid_d      = 1'b1;
      hdr_d        = '0;
      hdr_d[19:16] = 4'hF;
      hdr_d[15]    = is_hint[grant_idx];
      hdr_d[5:0]   = 6'(grant_idx);
      odata_d      = is_hint[grant_idx] ? '0 : slot_data[grant_idx];
    end else if (umsg_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      ptr_q   <= ID_W'(NUM_UMSG - 1);
      valid_q <= 1'b0;
      hdr_q   <= '0;
      odata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      hdr_q   <= hdr_d;
      odata_q <= odata_d;
    end
  end

  assign umsg_valid = valid_q;
  assign umsg_hdr   = hdr_q;
  assign umsg_data  = odata_q;

`ifdef ASE_UMSG_STATS_EN
  logic [31:0] hint_cnt_q, hint_cnt_d;
  logic [31:0] data_cnt_q, data_cnt_d;
  logic [31:0] coal_cnt_q, coal_cnt_d;
  logic        coal_evt;

  always_comb begin
    // A command landing on a slot whose data message is granted this edge is a new message, not a coalesce.
    coal_evt   = cmd_acc && slot_busy[umsgcmd_id] &&
                 !(grant_valid && (grant_idx == umsgcmd_id) && !is_hint[grant_idx]);
    hint_cnt_d = hint_cnt_q;
    data_cnt_d = data_cnt_q;
    coal_cnt_d = coal_cnt_q;
    if (valid_q && umsg_ready) begin
      if (hdr_q[15]) hint_cnt_d = hint_cnt_q + 32'd1;
      else           data_cnt_d = data_cnt_q + 32'd1;
    end
    if (coal_evt) coal_cnt_d = coal_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      hint_cnt_q <= '0;
      data_cnt_q <= '0;
      coal_cnt_q <= '0;
    end else begin
      hint_cnt_q <= hint_cnt_d;
      data_cnt_q <= data_cnt_d;
      coal_cnt_q <= coal_cnt_d;
    end
  end

  assign stat_hint_cnt     = hint_cnt_q;
  assign stat_data_cnt     = data_cnt_q;
  assign stat_coalesce_cnt = coal_cnt_q;
`else
  assign stat_hint_cnt     = '0;
  assign stat_data_cnt     = '0;
  assign stat_coalesce_cnt = '0;
`endif

endmodule

// File: tb/tb_ase_umsg_scheduler.sv
// Directed bench for ase_umsg_scheduler (HINT_DELAY=8, DATA_DELAY=4); one task per scenario.
module tb_ase_umsg_scheduler;
  localparam int N = 8;
`ifdef ASE_UMSG_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  localparam logic [511:0] DA = {16{32'hAAAA_0001}};
  localparam logic [511:0] DB = {16{32'hBBBB_0002}};
  localparam logic [511:0] DC = {16{32'hCCCC_0003}};
  localparam logic [511:0] DD = {16{32'hDDDD_0004}};

  logic         clk = 1'b0;
  logic         SoftReset_n = 1'b0;
  logic         umsg_en = 1'b1;
  logic         umsgcmd_valid = 1'b0;
  logic [2:0]   umsgcmd_id = '0;
  logic         umsgcmd_hint = 1'b0;
  logic [511:0] umsgcmd_data = '0;
  logic         umsg_valid;
  logic         umsg_ready = 1'b1;
  logic [27:0]  umsg_hdr;
  logic [511:0] umsg_data;
  logic [N-1:0] slot_busy;
  logic [31:0]  stat_hint_cnt, stat_data_cnt, stat_coalesce_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  int           q_cyc[$];
  logic [27:0]  q_hdr[$];
  logic [511:0] q_data[$];

  ase_umsg_scheduler #(.NUM_UMSG(N), .TIMER_WIDTH(8), .HINT_DELAY(8), .DATA_DELAY(4)) dut (
    .clk(clk), .SoftReset_n(SoftReset_n), .umsg_en(umsg_en),
    .umsgcmd_valid(umsgcmd_valid), .umsgcmd_id(umsgcmd_id), .umsgcmd_hint(umsgcmd_hint),
    .umsgcmd_data(umsgcmd_data), .umsg_valid(umsg_valid), .umsg_ready(umsg_ready),
    .umsg_hdr(umsg_hdr), .umsg_data(umsg_data), .slot_busy(slot_busy),
    .stat_hint_cnt(stat_hint_cnt), .stat_data_cnt(stat_data_cnt),
    .stat_coalesce_cnt(stat_coalesce_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [27:0] exp_hdr(input int id, input bit hint);
    return {8'h00, 4'hF, hint, 9'h000, 6'(id)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    SoftReset_n = 1'b0;
    umsgcmd_valid = 1'b0;
    tick();
    SoftReset_n = 1'b1;
  endtask

  task automatic send_cmd(input int id, input bit hint, input logic [511:0] data);
    umsgcmd_valid = 1'b1;
    umsgcmd_id    = 3'(id);
    umsgcmd_hint  = hint;
    umsgcmd_data  = data;
    tick();
    umsgcmd_valid = 1'b0;
  endtask

  // Records every message handed off (valid & ready) over ncyc edges, stamped with the edge number.
  task automatic collect(input int ncyc);
    q_cyc.delete(); q_hdr.delete(); q_data.delete();
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (umsg_valid && umsg_ready) begin
        q_cyc.push_back(c); q_hdr.push_back(umsg_hdr); q_data.push_back(umsg_data);
        $display("msg edge=%0d id=%0d type=%0b data[31:0]=%h", c, umsg_hdr[5:0], umsg_hdr[15], umsg_data[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vec_cnt++; if (umsg_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", umsg_valid); end
    vec_cnt++; if (umsg_hdr !== 28'h0) begin err_cnt++; $display("FAIL reset_hdr: got %h want 0", umsg_hdr); end
    vec_cnt++; if (umsg_data !== 512'h0) begin err_cnt++; $display("FAIL reset_data: got %h want 0", umsg_data[31:0]); end
    vec_cnt++; if (slot_busy !== 8'h00) begin err_cnt++; $display("FAIL reset_busy: got %h want 00", slot_busy); end
    vec_cnt++; if ({stat_hint_cnt, stat_data_cnt, stat_coalesce_cnt} !== 96'h0) begin
      err_cnt++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", stat_hint_cnt, stat_data_cnt, stat_coalesce_cnt); end
  endtask

  task automatic test_enable();
    apply_reset();
    umsg_en = 1'b0;
    send_cmd(6, 1'b0, DA);
    umsg_en = 1'b1;
    vec_cnt++; if (slot_busy !== 8'h00) begin err_cnt++; $display("FAIL en_busy: got %h want 00", slot_busy); end
    collect(10);
    vec_cnt++; if (q_cyc.size() != 0) begin err_cnt++; $display("FAIL en_msgs: got %0d want 0", q_cyc.size()); end
  endtask

  task automatic test_data_only();
    apply_reset();
    umsg_ready = 1'b1;
    send_cmd(3, 1'b0, DA);
    collect(8);
    vec_cnt++; if (q_cyc.size() != 1) begin err_cnt++; $display("FAIL t1_count: got %0d want 1", q_cyc.size()); end
    else begin
      vec_cnt++; if (q_cyc[0] != 5) begin err_cnt++; $display("FAIL t1_latency: got %0d want 5", q_cyc[0]); end
      vec_cnt++; if (q_hdr[0] !== exp_hdr(3, 1'b0)) begin err_cnt++; $display("FAIL t1_hdr: got %h want %h", q_hdr[0], exp_hdr(3, 1'b0)); end
      vec_cnt++; if (q_data[0] !== DA) begin err_cnt++; $display("FAIL t1_data: got %h want %h", q_data[0][31:0], DA[31:0]); end
    end
    vec_cnt++; if (slot_busy[3] !== 1'b0) begin err_cnt++; $display("FAIL t1_busy: got %b want 0", slot_busy[3]); end
  endtask

  task automatic test_hint();
    apply_reset();
    umsg_ready = 1'b1;
    send_cmd(1, 1'b1, DB);
    collect(20);
    vec_cnt++; if (q_cyc.size() != 2) begin err_cnt++; $display("FAIL t2_count: got %0d want 2", q_cyc.size()); end
    else begin
      vec_cnt++; if (q_cyc[0] != 9) begin err_cnt++; $display("FAIL t2_hint_lat: got %0d want 9", q_cyc[0]); end
      vec_cnt++; if (q_hdr[0] !== exp_hdr(1, 1'b1)) begin err_cnt++; $display("FAIL t2_hint_hdr: got %h want %h", q_hdr[0], exp_hdr(1, 1'b1)); end
      vec_cnt++; if (q_data[0] !== 512'h0) begin err_cnt++; $display("FAIL t2_hint_data: got %h want 0", q_data[0][31:0]); end
      vec_cnt++; if (q_cyc[1] != 14) begin err_cnt++; $display("FAIL t2_data_lat: got %0d want 14", q_cyc[1]); end
      vec_cnt++; if (q_hdr[1] !== exp_hdr(1, 1'b0)) begin err_cnt++; $display("FAIL t2_data_hdr: got %h want %h", q_hdr[1], exp_hdr(1, 1'b0)); end
      vec_cnt++; if (q_data[1] !== DB) begin err_cnt++; $display("FAIL t2_data: got %h want %h", q_data[1][31:0], DB[31:0]); end
    end
    vec_cnt++; if (stat_hint_cnt !== 32'(STATS)) begin err_cnt++; $display("FAIL t2_stat_hint: got %0d want %0d", stat_hint_cnt, STATS); end
    vec_cnt++; if (stat_data_cnt !== 32'(STATS)) begin err_cnt++; $display("FAIL t2_stat_data: got %0d want %0d", stat_data_cnt, STATS); end
  endtask

  task automatic test_round_robin();
    logic [511:0] exp_d[3];
    exp_d[0] = DA; exp_d[1] = DB; exp_d[2] = DC;
    apply_reset();
    umsg_ready = 1'b0;
    send_cmd(7, 1'b0, DD);
    send_cmd(2, 1'b0, DC);
    send_cmd(1, 1'b0, DB);
    send_cmd(0, 1'b0, DA);
    for (int i = 0; i < 6; i++) tick();
    vec_cnt++; if (umsg_valid !== 1'b1 || umsg_hdr !== exp_hdr(7, 1'b0)) begin
      err_cnt++; $display("FAIL t3_hold: got valid=%b hdr=%h want 1/%h", umsg_valid, umsg_hdr, exp_hdr(7, 1'b0)); end
    vec_cnt++; if (slot_busy !== 8'h07) begin err_cnt++; $display("FAIL t3_busy: got %h want 07", slot_busy); end
    umsg_ready = 1'b1;
    collect(6);
    vec_cnt++; if (q_cyc.size() != 3) begin err_cnt++; $display("FAIL t3_count: got %0d want 3", q_cyc.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        vec_cnt++; if (q_cyc[i] != i + 1 || q_hdr[i] !== exp_hdr(i, 1'b0) || q_data[i] !== exp_d[i]) begin
          err_cnt++; $display("FAIL t3_order[%0d]: got edge=%0d hdr=%h want edge=%0d hdr=%h", i, q_cyc[i], q_hdr[i], i + 1, exp_hdr(i, 1'b0)); end
      end
    end
    // Pointer now at 2; slots 0 and 2 request together behind a held slot-2 message.
    umsg_ready = 1'b0;
    send_cmd(2, 1'b0, DD);
    for (int i = 0; i < 5; i++) tick();
    send_cmd(2, 1'b0, DB);
    send_cmd(0, 1'b0, DC);
    for (int i = 0; i < 5; i++) tick();
    vec_cnt++; if (umsg_hdr !== exp_hdr(2, 1'b0) || umsg_data !== DD) begin
      err_cnt++; $display("FAIL t3b_hold: got hdr=%h data=%h want %h/%h", umsg_hdr, umsg_data[31:0], exp_hdr(2, 1'b0), DD[31:0]); end
    vec_cnt++; if (slot_busy !== 8'h05) begin err_cnt++; $display("FAIL t3b_busy: got %h want 05", slot_busy); end
    umsg_ready = 1'b1;
    collect(4);
    vec_cnt++; if (q_cyc.size() != 2) begin err_cnt++; $display("FAIL t3b_count: got %0d want 2", q_cyc.size()); end
    else begin
      vec_cnt++; if (q_hdr[0] !== exp_hdr(0, 1'b0) || q_data[0] !== DC || q_cyc[0] != 1) begin
        err_cnt++; $display("FAIL t3b_first: got edge=%0d hdr=%h want edge=1 hdr=%h", q_cyc[0], q_hdr[0], exp_hdr(0, 1'b0)); end
      vec_cnt++; if (q_hdr[1] !== exp_hdr(2, 1'b0) || q_data[1] !== DB || q_cyc[1] != 2) begin
        err_cnt++; $display("FAIL t3b_second: got edge=%0d hdr=%h want edge=2 hdr=%h", q_cyc[1], q_hdr[1], exp_hdr(2, 1'b0)); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    umsg_ready = 1'b0;
    send_cmd(3, 1'b0, DA);
    send_cmd(4, 1'b0, DB);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      vec_cnt++; if (umsg_valid !== 1'b1 || umsg_hdr !== exp_hdr(3, 1'b0) || umsg_data !== DA || slot_busy[4] !== 1'b1) begin
        err_cnt++; $display("FAIL t4_stall[%0d]: got valid=%b hdr=%h busy4=%b want 1/%h/1", i, umsg_valid, umsg_hdr, slot_busy[4], exp_hdr(3, 1'b0)); end
    end
    umsg_ready = 1'b1;
    tick();
    vec_cnt++; if (umsg_valid !== 1'b1 || umsg_hdr !== exp_hdr(4, 1'b0) || umsg_data !== DB) begin
      err_cnt++; $display("FAIL t4_release: got valid=%b hdr=%h data=%h want 1/%h/%h", umsg_valid, umsg_hdr, umsg_data[31:0], exp_hdr(4, 1'b0), DB[31:0]); end
  endtask

  task automatic test_coalesce();
    apply_reset();
    umsg_ready = 1'b1;
    send_cmd(5, 1'b0, DA);
    tick();
    send_cmd(5, 1'b1, DB);
    collect(12);
    vec_cnt++; if (q_cyc.size() != 1) begin err_cnt++; $display("FAIL t5_count: got %0d want 1", q_cyc.size()); end
    else begin
      vec_cnt++; if (q_hdr[0] !== exp_hdr(5, 1'b0) || q_data[0] !== DB || q_cyc[0] != 3) begin
        err_cnt++; $display("FAIL t5_msg: got edge=%0d hdr=%h data=%h want edge=3 hdr=%h data=%h", q_cyc[0], q_hdr[0], q_data[0][31:0], exp_hdr(5, 1'b0), DB[31:0]); end
    end
    vec_cnt++; if (stat_coalesce_cnt !== 32'(STATS)) begin err_cnt++; $display("FAIL t5_stat_coal: got %0d want %0d", stat_coalesce_cnt, STATS); end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    umsg_ready = 1'b0;
    send_cmd(0, 1'b0, DA);
    send_cmd(1, 1'b0, DB);
    send_cmd(2, 1'b1, DC);
    send_cmd(3, 1'b0, DD);
    for (int i = 0; i < 3; i++) tick();
    vec_cnt++; if (umsg_valid !== 1'b1 || slot_busy !== 8'h0E) begin
      err_cnt++; $display("FAIL t6_pre: got valid=%b busy=%h want 1/0e", umsg_valid, slot_busy); end
    SoftReset_n = 1'b0;
    tick();
    SoftReset_n = 1'b1;
    vec_cnt++; if (umsg_valid !== 1'b0 || slot_busy !== 8'h00 || umsg_hdr !== 28'h0 || umsg_data !== 512'h0) begin
      err_cnt++; $display("FAIL t6_post: got valid=%b busy=%h hdr=%h want 0/00/0", umsg_valid, slot_busy, umsg_hdr); end
    vec_cnt++; if ({stat_hint_cnt, stat_data_cnt, stat_coalesce_cnt} !== 96'h0) begin
      err_cnt++; $display("FAIL t6_stats: got %0d/%0d/%0d want 0/0/0", stat_hint_cnt, stat_data_cnt, stat_coalesce_cnt); end
    umsg_ready = 1'b1;
    collect(30);
    vec_cnt++; if (q_cyc.size() != 0) begin err_cnt++; $display("FAIL t6_quiet: got %0d msgs want 0", q_cyc.size()); end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_data_only();
    test_hint();
    test_round_robin();
    test_backpressure();
    test_coalesce();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/ase_umsg_scheduler.md
Name: ase_umsg_scheduler

Overview:
- Per-slot UMsg sequencer and arbiter for the ASE CCI-P emulator.
- Accepts UMsg commands from the software-side DPI path and runs one hint/data state machine per UMsg slot, with per-slot delay timers.
- Round-robins ready slots onto a single registered UMsg output toward the RX0 channel mux.
- Hint messages are optional per command.

Parameters:
- NUM_UMSG, 8, number of UMsg slots per AFU.
- TIMER_WIDTH, 8, width of the per-slot delay timers.
- HINT_DELAY, 16, cycles from command accept to hint eligibility; must be >=1.
- DATA_DELAY, 16, cycles from entering DataWait to data eligibility; must be >=1.

Ports:
- clk  in  1  clock; all logic rises on this edge.
- SoftReset_n  in  1  synchronous reset, active-low.
- umsg_en  in  1  global enable. When 0, new commands are ignored.
- umsgcmd_valid  in  1  command strobe, one per cycle, always accepted.
- umsgcmd_id  in  $clog2(NUM_UMSG)  target slot.
- umsgcmd_hint  in  1  1 = send a hint before the data.
- umsgcmd_data  in  512  cache-line payload.
- umsg_valid  out  1  output message valid.
- umsg_ready  in  1  downstream accept.
- umsg_hdr  out  28  UMsgHdr_t-layout header.
- umsg_data  out  512  payload; zero for hints.
- slot_busy  out  NUM_UMSG  per-slot, high when state != Idle.
- stat_hint_cnt, stat_data_cnt, stat_coalesce_cnt  out  32 each  statistics (see Optional Feature).

Behaviour:
- Reset, synchronous, active-low: at the first edge with SoftReset_n=0, every slot goes Idle, timers=0 and data registers=0. Outputs: umsg_valid=0, umsg_hdr=0, umsg_data=0, slot_busy=0, statistics=0. RR pointer=NUM_UMSG-1, so slot 0 has first priority. Reset mid-operation discards everything, including a held output.
- Per-slot states: Idle, HintWait, SendHint, DataWait, SendData.
  - Idle + accepted cmd: hint=1 goes to HintWait with timer=HINT_DELAY-1; hint=0 goes to DataWait with timer=DATA_DELAY-1. The data register is loaded.
  - HintWait/DataWait: timer decrements each edge. At timer==0 the slot moves to SendHint/SendData. Each wait therefore lasts exactly DELAY cycles.
  - SendHint + grant: goes to DataWait with timer=DATA_DELAY-1.
  - SendData + grant: goes to Idle. If a command for the same slot is accepted on the grant edge, it is treated as a new message and starts HintWait/DataWait.
- Accepted command = umsgcmd_valid & umsg_en.
- Command to a busy slot (coalesce):
  - The data register is overwritten (latest wins). State and timer are unchanged and no extra message is generated.
  - A message already captured in the output register is unaffected.
  - The hint bit of a coalesced command is ignored.
- Arbiter:
  - Requesters are slots in SendHint or SendData.
  - Grant is possible when umsg_valid==0 or (umsg_valid & umsg_ready).
  - One grant per cycle. Search starts at pointer+1 modulo NUM_UMSG; the pointer updates to the granted slot.
  - Non-granted slots hold their state.
- Output register:
  - The grant edge loads umsg_valid=1, the header and umsg_data. Data is the slot's data register, or 0 for a hint.
  - The output is held stable while umsg_valid & !umsg_ready.
  - umsg_valid clears on accept if there is no new grant.
  - Back-to-back messages are possible with umsg_ready=1: one per cycle.
- Header fields: resp_type=4'hF, umsg_type=1 for hint and 0 for data, umsg_id=slot (zero-extended to 6 bits). Poison and all reserved fields are 0.
- Latency, hint=0 with idle output: cmd edge E0, SendData at E0+DATA_DELAY, umsg_valid at E0+DATA_DELAY+1.
- Elaboration: HINT_DELAY or DATA_DELAY equal to 0, or exceeding 2**TIMER_WIDTH, is a fatal error.

Optional Feature:
- Macro: ASE_UMSG_STATS_EN.
- When defined, three 32-bit wrapping counters are maintained, each incrementing on the named event:
  - stat_hint_cnt: hint accepted (umsg_valid & umsg_ready & type=1).
  - stat_data_cnt: data accepted (the same handshake with type=0).
  - stat_coalesce_cnt: a coalesced command.
- Counters clear on reset.
- When not defined, the counters are not built and the three ports are tied to 0.

Test Plan:
1. HINT_DELAY=8, DATA_DELAY=4, umsg_ready=1; cmd id=3, hint=0, data=A at E0. Expect umsg_valid only at E0+5 with hdr umsg_id=3, umsg_type=0, resp_type=F, data=A, then slot_busy[3]=0.
2. Same config, cmd id=1, hint=1. Expect a hint at E0+9 (umsg_type=1, data=0), then data at E0+9+5=E0+14. Stats: hint=1, data=1.
3. Slots 0, 1 and 2 reach SendData on the same edge, umsg_ready=1. Expect outputs 0,1,2 on consecutive cycles. Next, slots 0 and 2 become ready together with pointer=2: expect 0 then 2.
4. Drive umsg_ready=0 for 10 cycles while umsg_valid=1 and slot 4 is in SendData. Expect hdr/data stable, slot 4 held in SendData, and slot 4's message on the cycle after umsg_ready returns high.
5. cmd slot 5, data=A, then data=B during DataWait. Expect a single data message with B; stat_coalesce_cnt=1 with ASE_UMSG_STATS_EN, 0 without.
6. Assert SoftReset_n=0 for one cycle while 3 slots are busy and umsg_valid=1. Expect umsg_valid=0, slot_busy=0 and stats=0 after the reset edge, and no further messages without new commands.
